// File: rtl/stencil_prefetcher_if.sv
// Request/response bundle between the access monitor, the stencil prefetcher
// and the memory-request queue.
interface stencil_prefetcher_if #(
    parameter int ADDR_W = 32
);
    logic              in_valid;
    logic              in_ready;
    logic [ADDR_W-1:0] in_index;
    logic [ADDR_W-1:0] in_base;
    logic              in_full;
    logic              in_wrap;
    logic              out_valid;
    logic              out_ready;
    logic [ADDR_W-1:0] out_addr;
    logic              out_last;
    logic              done;
    logic [4:0]        done_count;
    logic              done_err;

    modport master (
        output in_valid, in_index, in_base, in_full, in_wrap, out_ready,
        input  in_ready, out_valid, out_addr, out_last, done, done_count, done_err
    );

    modport slave (
        input  in_valid, in_index, in_base, in_full, in_wrap, out_ready,
        output in_ready, out_valid, out_addr, out_last, done, done_count, done_err
    );
endinterface

// File: rtl/stencil_prefetcher.sv
// 3D grid neighbour prefetcher: turns one cell index into a stream of
// neighbour byte addresses (6-face or 26-cube stencil, optional torus wrap).
module stencil_prefetcher #(
    parameter int ADDR_W     = 32,
    parameter int X_SIZE     = 3,
    parameter int Y_SIZE     = 3,
    parameter int Z_SIZE     = 3,
    parameter int ELEM_BYTES = 4
) (
    input logic                 clock,
    input logic                 reset_n,
    stencil_prefetcher_if.slave bus
);

    localparam logic [ADDR_W-1:0] X_W     = ADDR_W'(X_SIZE);
    localparam logic [ADDR_W-1:0] Y_W     = ADDR_W'(Y_SIZE);
    localparam logic [ADDR_W-1:0] XY_W    = ADDR_W'(X_SIZE * Y_SIZE);
    localparam logic [ADDR_W-1:0] CELLS_W = ADDR_W'(X_SIZE * Y_SIZE * Z_SIZE);
    localparam logic [ADDR_W-1:0] X_LAST  = ADDR_W'(X_SIZE - 1);
    localparam logic [ADDR_W-1:0] Y_LAST  = ADDR_W'(Y_SIZE - 1);
    localparam logic [ADDR_W-1:0] Z_LAST  = ADDR_W'(Z_SIZE - 1);
    localparam logic [ADDR_W-1:0] ELEM_W  = ADDR_W'(ELEM_BYTES);

    typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

    state_t            state;
    state_t            state_next;

    logic [ADDR_W-1:0] base_q;
    logic [ADDR_W-1:0] x_q;
    logic [ADDR_W-1:0] y_q;
    logic [ADDR_W-1:0] z_q;
    logic              full_q;
    logic              wrap_q;
    logic              err_q;
    logic [4:0]        total_q;
    logic [4:0]        k_q;
    logic [4:0]        e_q;

    logic [ADDR_W-1:0] idx_x;
    logic [ADDR_W-1:0] idx_y;
    logic [ADDR_W-1:0] idx_z;
    logic              in_range;
    logic [4:0]        cx;
    logic [4:0]        cy;
    logic [4:0]        cz;
    logic [4:0]        total_calc;

    logic [4:0]        pos;
    logic [1:0]        dx;
    logic [1:0]        dy;
    logic [1:0]        dz;
    logic [ADDR_W:0]   sx;
    logic [ADDR_W:0]   sy;
    logic [ADDR_W:0]   sz;
    logic [ADDR_W-1:0] nidx;
    logic [ADDR_W-1:0] cand_addr;
    logic              cand_valid;
    logic [4:0]        last_k;
    logic              accept;
    logic              handshake;
    logic              advance;

    // Move one step along an axis (d: 0 = -1, 1 = stay, 2 = +1); the top bit
    // flags whether the resulting coordinate is usable.
    function automatic logic [ADDR_W:0] step_axis(
        input logic [ADDR_W-1:0] c,
        input logic [1:0]        d,
        input logic [ADDR_W-1:0] last,
        input logic              wrap
    );
        step_axis = {1'b1, c};
        if (d == 2'd0) begin
            if (c == '0) step_axis = {wrap, last};
            else         step_axis = {1'b1, c - ADDR_W'(1)};
        end else if (d == 2'd2) begin
            if (c == last) step_axis = {wrap, {ADDR_W{1'b0}}};
            else           step_axis = {1'b1, c + ADDR_W'(1)};
        end
    endfunction

    // Decompose the incoming index and size its neighbour set at accept time.
    always_comb begin
        idx_x    = bus.in_index % X_W;
        idx_y    = (bus.in_index / X_W) % Y_W;
        idx_z    = bus.in_index / XY_W;
        in_range = bus.in_index < CELLS_W;
        cx = bus.in_wrap ? 5'd3 : 5'd1 + {4'd0, idx_x != '0} + {4'd0, idx_x < X_LAST};
        cy = bus.in_wrap ? 5'd3 : 5'd1 + {4'd0, idx_y != '0} + {4'd0, idx_y < Y_LAST};
        cz = bus.in_wrap ? 5'd3 : 5'd1 + {4'd0, idx_z != '0} + {4'd0, idx_z < Z_LAST};
        total_calc = bus.in_full ? (cx * cy * cz) - 5'd1 : cx + cy + cz - 5'd3;
    end

    // Map candidate k to an offset; in cube mode k skips the centre cell (13).
    always_comb begin
        dx  = 2'd1;
        dy  = 2'd1;
        dz  = 2'd1;
        pos = '0;
        if (full_q) begin
            pos = k_q + {4'd0, k_q >= 5'd13};
            dx  = 2'(pos % 5'd3);
            dy  = 2'((pos / 5'd3) % 5'd3);
            dz  = 2'(pos / 5'd9);
        end else begin
            case (k_q)
                5'd0:    dx = 2'd0;
                5'd1:    dx = 2'd2;
                5'd2:    dy = 2'd0;
                5'd3:    dy = 2'd2;
                5'd4:    dz = 2'd0;
                5'd5:    dz = 2'd2;
                default: ;
            endcase
        end
    end

    always_comb begin
        sx         = step_axis(x_q, dx, X_LAST, wrap_q);
        sy         = step_axis(y_q, dy, Y_LAST, wrap_q);
        sz         = step_axis(z_q, dz, Z_LAST, wrap_q);
        cand_valid = sx[ADDR_W] && sy[ADDR_W] && sz[ADDR_W];
        nidx       = sx[ADDR_W-1:0] + sy[ADDR_W-1:0] * X_W + sz[ADDR_W-1:0] * XY_W;
        cand_addr  = base_q + nidx * ELEM_W;
        last_k     = full_q ? 5'd25 : 5'd5;
    end

    always_comb begin
        accept    = (state == IDLE) && bus.in_valid;
        handshake = (state == SCAN) && cand_valid && bus.out_ready;
        advance   = (state == SCAN) && (!cand_valid || bus.out_ready);
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (bus.in_valid) state_next = in_range ? SCAN : DONE;
            SCAN:    if (advance && (k_q == last_k)) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Request context and candidate/emit counters.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            base_q  <= '0;
            x_q     <= '0;
            y_q     <= '0;
            z_q     <= '0;
            full_q  <= 1'b0;
            wrap_q  <= 1'b0;
            err_q   <= 1'b0;
            total_q <= '0;
            k_q     <= '0;
            e_q     <= '0;
        end else if (accept) begin
            base_q  <= bus.in_base;
            x_q     <= idx_x;
            y_q     <= idx_y;
            z_q     <= idx_z;
            full_q  <= bus.in_full;
            wrap_q  <= bus.in_wrap;
            err_q   <= !in_range;
            total_q <= in_range ? total_calc : 5'd0;
            k_q     <= '0;
            e_q     <= '0;
        end else begin
            if (advance)   k_q <= k_q + 5'd1;
            if (handshake) e_q <= e_q + 5'd1;
        end
    end

    // Outputs decode straight from state so reset clears them asynchronously.
    always_comb begin
        bus.in_ready   = (state == IDLE);
        bus.out_valid  = (state == SCAN) && cand_valid;
        bus.out_addr   = bus.out_valid ? cand_addr : '0;
        bus.out_last   = bus.out_valid && (e_q == total_q - 5'd1);
        bus.done       = (state == DONE);
        bus.done_count = (state == DONE) ? e_q : 5'd0;
        bus.done_err   = (state == DONE) && err_q;
    end

endmodule

// File: tb/tb_stencil_prefetcher.sv
// Directed bench for stencil_prefetcher on a 3x3x3 grid with 4-byte cells.
module tb_stencil_prefetcher;

    logic clock   = 1'b0;
    logic reset_n = 1'b1;

    always #5 clock = ~clock;

    stencil_prefetcher_if #(.ADDR_W(32)) bus ();

    stencil_prefetcher #(
        .ADDR_W(32), .X_SIZE(3), .Y_SIZE(3), .Z_SIZE(3), .ELEM_BYTES(4)
    ) dut (
        .clock  (clock),
        .reset_n(reset_n),
        .bus    (bus)
    );

    int          n_compared   = 0;
    int          n_mismatched = 0;

    logic [31:0] got_addr[32];
    logic        got_last[32];
    int          got_n;
    int          got_bubbles;
    int          got_done_cycle;
    logic [4:0]  got_count;
    logic        got_err;

    // Present one request for a single cycle; the DUT must be idle.
    task automatic issue(input logic [31:0] idx, input logic [31:0] base,
                         input logic full, input logic wrap);
        @(negedge clock);
        bus.in_index = idx;
        bus.in_base  = base;
        bus.in_full  = full;
        bus.in_wrap  = wrap;
        bus.in_valid = 1'b1;
        @(posedge clock);
        #1 bus.in_valid = 1'b0;
    endtask

    // Record the stream with out_ready held high; cycle 0 is the cycle after accept.
    task automatic collect();
        got_n          = 0;
        got_bubbles    = 0;
        got_done_cycle = -1;
        got_count      = '0;
        got_err        = 1'b0;
        bus.out_ready  = 1'b1;
        for (int c = 0; c < 64; c++) begin
            @(negedge clock);
            if (bus.done) begin
                got_done_cycle = c;
                got_count      = bus.done_count;
                got_err        = bus.done_err;
                break;
            end
            if (bus.out_valid) begin
                if (got_n < 32) begin
                    got_addr[got_n] = bus.out_addr;
                    got_last[got_n] = bus.out_last;
                end
                got_n++;
            end else begin
                got_bubbles++;
            end
        end
    endtask

    task automatic test_reset();
        logic [31:0] obs[7];
        logic [31:0] exp_v[7] = '{32'd1, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0};
        string       name[7]  = '{"in_ready", "out_valid", "out_addr", "out_last",
                                  "done", "done_count", "done_err"};
        #1 reset_n = 1'b0;
        #1;
        obs = '{32'(bus.in_ready), 32'(bus.out_valid), bus.out_addr, 32'(bus.out_last),
                32'(bus.done), 32'(bus.done_count), 32'(bus.done_err)};
        for (int i = 0; i < 7; i++) begin
            n_compared++;
            if (obs[i] !== exp_v[i]) begin
                n_mismatched++;
                $display("[TB] FAIL reset_%s: got %0h expected %0h", name[i], obs[i], exp_v[i]);
            end
        end
        repeat (3) @(negedge clock);
        reset_n = 1'b1;
    endtask

    task automatic test_face_interior();
        logic [31:0] exp_addr[6] = '{32'h1030, 32'h1038, 32'h1028, 32'h1040, 32'h1010, 32'h1058};
        issue(32'd13, 32'h1000, 1'b0, 1'b0);
        collect();
        n_compared++;
        if (got_n != 6) begin
            n_mismatched++;
            $display("[TB] FAIL face_interior_n: got %0d expected 6", got_n);
        end
        for (int i = 0; i < 6; i++) begin
            n_compared++;
            if (got_addr[i] !== exp_addr[i] || got_last[i] !== (i == 5)) begin
                n_mismatched++;
                $display("[TB] FAIL face_interior_out%0d: got addr %h last %b expected addr %h last %b",
                         i, got_addr[i], got_last[i], exp_addr[i], (i == 5));
            end
        end
        n_compared++;
        if (got_done_cycle != 6 || got_count !== 5'd6 || got_err !== 1'b0) begin
            n_mismatched++;
            $display("[TB] FAIL face_interior_done: got cycle %0d count %0d err %b expected cycle 6 count 6 err 0",
                     got_done_cycle, got_count, got_err);
        end
    endtask

    task automatic test_cube_corner();
        logic [31:0] exp_addr[7] = '{32'd4, 32'd12, 32'd16, 32'd36, 32'd40, 32'd48, 32'd52};
        issue(32'd0, 32'd0, 1'b1, 1'b0);
        collect();
        n_compared++;
        if (got_n != 7 || got_bubbles != 19) begin
            n_mismatched++;
            $display("[TB] FAIL cube_corner_shape: got n %0d bubbles %0d expected n 7 bubbles 19",
                     got_n, got_bubbles);
        end
        for (int i = 0; i < 7; i++) begin
            n_compared++;
            if (got_addr[i] !== exp_addr[i] || got_last[i] !== (i == 6)) begin
                n_mismatched++;
                $display("[TB] FAIL cube_corner_out%0d: got addr %h last %b expected addr %h last %b",
                         i, got_addr[i], got_last[i], exp_addr[i], (i == 6));
            end
        end
        n_compared++;
        if (got_done_cycle != 26 || got_count !== 5'd7 || got_err !== 1'b0) begin
            n_mismatched++;
            $display("[TB] FAIL cube_corner_done: got cycle %0d count %0d err %b expected cycle 26 count 7 err 0",
                     got_done_cycle, got_count, got_err);
        end
    endtask

    task automatic test_face_wrap();
        logic [31:0] exp_addr[6] = '{32'd8, 32'd4, 32'd24, 32'd12, 32'd72, 32'd36};
        issue(32'd0, 32'd0, 1'b0, 1'b1);
        collect();
        n_compared++;
        if (got_n != 6) begin
            n_mismatched++;
            $display("[TB] FAIL face_wrap_n: got %0d expected 6", got_n);
        end
        for (int i = 0; i < 6; i++) begin
            n_compared++;
            if (got_addr[i] !== exp_addr[i] || got_last[i] !== (i == 5)) begin
                n_mismatched++;
                $display("[TB] FAIL face_wrap_out%0d: got addr %h last %b expected addr %h last %b",
                         i, got_addr[i], got_last[i], exp_addr[i], (i == 5));
            end
        end
        n_compared++;
        if (got_count !== 5'd6 || got_err !== 1'b0) begin
            n_mismatched++;
            $display("[TB] FAIL face_wrap_done: got count %0d err %b expected count 6 err 0",
                     got_count, got_err);
        end
    endtask

    task automatic test_out_of_range();
        issue(32'd27, 32'h1000, 1'b0, 1'b0);
        collect();
        n_compared++;
        if (got_n != 0 || got_done_cycle != 0 || got_err !== 1'b1 || got_count !== 5'd0) begin
            n_mismatched++;
            $display("[TB] FAIL out_of_range: got n %0d cycle %0d err %b count %0d expected n 0 cycle 0 err 1 count 0",
                     got_n, got_done_cycle, got_err, got_count);
        end
    endtask

    // Far corner right after an error request: only the three minus-side faces exist.
    task automatic test_back_to_back();
        logic [31:0] exp_addr[3] = '{32'd100, 32'd92, 32'd68};
        issue(32'd26, 32'd0, 1'b0, 1'b0);
        collect();
        n_compared++;
        if (got_n != 3 || got_bubbles != 3) begin
            n_mismatched++;
            $display("[TB] FAIL back_to_back_shape: got n %0d bubbles %0d expected n 3 bubbles 3",
                     got_n, got_bubbles);
        end
        for (int i = 0; i < 3; i++) begin
            n_compared++;
            if (got_addr[i] !== exp_addr[i] || got_last[i] !== (i == 2)) begin
                n_mismatched++;
                $display("[TB] FAIL back_to_back_out%0d: got addr %h last %b expected addr %h last %b",
                         i, got_addr[i], got_last[i], exp_addr[i], (i == 2));
            end
        end
        n_compared++;
        if (got_count !== 5'd3 || got_err !== 1'b0) begin
            n_mismatched++;
            $display("[TB] FAIL back_to_back_done: got count %0d err %b expected count 3 err 0",
                     got_count, got_err);
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] exp_addr[6] = '{32'h1030, 32'h1038, 32'h1028, 32'h1040, 32'h1010, 32'h1058};
        logic [31:0] prev_addr   = '0;
        logic        prev_last   = 1'b0;
        logic        prev_stall  = 1'b0;
        logic        seen_done   = 1'b0;
        logic [4:0]  cnt         = '0;
        int          n           = 0;
        issue(32'd13, 32'h1000, 1'b0, 1'b0);
        for (int c = 0; c < 64; c++) begin
            @(negedge clock);
            bus.out_ready = (c % 2) == 1;
            if (bus.done) begin
                seen_done = 1'b1;
                cnt       = bus.done_count;
                break;
            end
            if (bus.out_valid) begin
                if (prev_stall) begin
                    n_compared++;
                    if (bus.out_addr !== prev_addr || bus.out_last !== prev_last) begin
                        n_mismatched++;
                        $display("[TB] FAIL backpressure_hold: got addr %h last %b expected addr %h last %b",
                                 bus.out_addr, bus.out_last, prev_addr, prev_last);
                    end
                end
                if (bus.out_ready) begin
                    n_compared++;
                    if (n >= 6 || bus.out_addr !== exp_addr[n] || bus.out_last !== (n == 5)) begin
                        n_mismatched++;
                        $display("[TB] FAIL backpressure_out%0d: got addr %h last %b expected addr %h last %b",
                                 n, bus.out_addr, bus.out_last, exp_addr[n % 6], (n == 5));
                    end
                    n++;
                    prev_stall = 1'b0;
                end else begin
                    prev_stall = 1'b1;
                    prev_addr  = bus.out_addr;
                    prev_last  = bus.out_last;
                end
            end
        end
        bus.out_ready = 1'b1;
        n_compared++;
        if (n != 6 || seen_done !== 1'b1 || cnt !== 5'd6) begin
            n_mismatched++;
            $display("[TB] FAIL backpressure_done: got n %0d done %b count %0d expected n 6 done 1 count 6",
                     n, seen_done, cnt);
        end
    endtask

    task automatic test_reset_mid_request();
        logic [31:0] exp_addr[3] = '{32'h2004, 32'h200C, 32'h2024};
        int          n           = 0;
        int          stray       = 0;
        bus.out_ready = 1'b1;
        issue(32'd13, 32'h1000, 1'b0, 1'b0);
        for (int c = 0; c < 32 && n < 2; c++) begin
            @(negedge clock);
            if (bus.out_valid) n++;
        end
        n_compared++;
        if (n != 2) begin
            n_mismatched++;
            $display("[TB] FAIL mid_reset_reach: got %0d outputs expected 2", n);
        end
        @(posedge clock);
        #2 reset_n = 1'b0;
        #1;
        n_compared++;
        if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || bus.out_addr !== 32'd0 ||
            bus.out_last !== 1'b0 || bus.done !== 1'b0 || bus.done_count !== 5'd0 ||
            bus.done_err !== 1'b0) begin
            n_mismatched++;
            $display("[TB] FAIL mid_reset_outputs: got rdy %b vld %b addr %h last %b done %b cnt %0d err %b expected 1 0 0 0 0 0 0",
                     bus.in_ready, bus.out_valid, bus.out_addr, bus.out_last,
                     bus.done, bus.done_count, bus.done_err);
        end
        repeat (2) @(negedge clock);
        reset_n = 1'b1;
        repeat (4) begin
            @(negedge clock);
            if (bus.done || bus.out_valid || !bus.in_ready) stray++;
        end
        n_compared++;
        if (stray != 0) begin
            n_mismatched++;
            $display("[TB] FAIL mid_reset_quiet: got %0d busy cycles expected 0", stray);
        end
        issue(32'd0, 32'h2000, 1'b0, 1'b0);
        collect();
        for (int i = 0; i < 3; i++) begin
            n_compared++;
            if (got_addr[i] !== exp_addr[i] || got_last[i] !== (i == 2)) begin
                n_mismatched++;
                $display("[TB] FAIL mid_reset_restart_out%0d: got addr %h last %b expected addr %h last %b",
                         i, got_addr[i], got_last[i], exp_addr[i], (i == 2));
            end
        end
        n_compared++;
        if (got_n != 3 || got_count !== 5'd3 || got_err !== 1'b0) begin
            n_mismatched++;
            $display("[TB] FAIL mid_reset_restart_done: got n %0d count %0d err %b expected n 3 count 3 err 0",
                     got_n, got_count, got_err);
        end
    endtask

    initial begin
        bus.in_valid  = 1'b0;
        bus.in_index  = '0;
        bus.in_base   = '0;
        bus.in_full   = 1'b0;
        bus.in_wrap   = 1'b0;
        bus.out_ready = 1'b1;
        test_reset();
        test_face_interior();
        test_cube_corner();
        test_face_wrap();
        test_out_of_range();
        test_back_to_back();
        test_backpressure();
        test_reset_mid_request();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got no completion expected finish before 200000");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
